// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives the ROM address, tracks the one-cycle
// registered-read latency, re-reads under decode stall and squashes the
// wrong-path word on a redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err
);

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] LAST_WORD = 32'(IMEM_BYTES - 4);
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam logic [31:0] WORD_STEP = 32'd4;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] f_pc_q, f_pc_d;
    logic            f_valid_q, f_valid_d;
    logic            f_oor_q, f_oor_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] redirect_tgt;
    logic            redirect_misaligned;

    // Word-aligned redirect target and its alignment fault
    always_comb begin
        redirect_tgt        = {redirect_pc[31:2], 2'b00};
        redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    end

    // Next-state: redirect beats stall; stall holds everything; else advance
    always_comb begin
        pc_d      = pc_q;
        f_pc_d    = f_pc_q;
        f_valid_d = f_valid_q;
        f_oor_d   = f_oor_q;
        err_d     = err_q;
        if (redirect_valid) begin
            f_pc_d    = redirect_tgt;
            pc_d      = redirect_tgt + WORD_STEP;
            f_valid_d = 1'b1;
            f_oor_d   = (redirect_tgt > LAST_WORD);
            err_d     = err_q | redirect_misaligned | f_oor_d;
        end else if (!stall) begin
            f_pc_d    = pc_q;
            pc_d      = pc_q + WORD_STEP;
            f_valid_d = 1'b1;
            f_oor_d   = (pc_q > LAST_WORD);
            err_d     = err_q | f_oor_d;
        end
    end

    // ROM address: re-driving f_pc during a stall keeps imem_rdata stable
    always_comb begin
        imem_addr = pc_q;
        if (redirect_valid) begin
            imem_addr = redirect_tgt;
        end else if (stall && f_valid_q) begin
            imem_addr = f_pc_q;
        end
    end

    // Decode-facing outputs; a same-cycle redirect squashes the word
    always_comb begin
        inst_valid = f_valid_q && !redirect_valid;
        inst       = f_oor_q ? NOP_INST : imem_rdata;
        inst_pc    = f_pc_q;
        fetch_err  = err_q;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            f_pc_q    <= '0;
            f_valid_q <= 1'b0;
            f_oor_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            f_pc_q    <= f_pc_d;
            f_valid_q <= f_valid_d;
            f_oor_q   <= f_oor_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: program-order stream model plus
// directed literal checks and a randomized stall/redirect/reset phase.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned IMEM_BYTES = 16384;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    inst_fetch #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    // ROM contents: a scrambled function of the word index (aliases above 16 KB)
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = {20'b0, a[13:2]};
        return (idx * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // A word is out of range when its four bytes do not all fit in the ROM
    function automatic bit word_oor(input logic [31:0] a);
        logic [63:0] end_byte;
        end_byte = 64'(a) + 64'd4;
        return end_byte > 64'(IMEM_BYTES);
    endfunction

    // Registered-read ROM
    always @(posedge clk) imem_rdata <= rom_word(imem_addr);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: the presented word and the next word in program order
    bit          m_valid = 1'b0;
    logic [31:0] m_cur   = '0;
    logic [31:0] m_next  = RESET_PC;
    bit          m_err   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_cur   = '0;
            m_next  = RESET_PC;
            m_err   = 1'b0;
        end else if (redirect_valid) begin
            m_cur   = redirect_pc & ~32'd3;
            m_next  = m_cur + 32'd4;
            m_valid = 1'b1;
            if (redirect_pc[1:0] != 2'b00 || word_oor(m_cur)) m_err = 1'b1;
        end else if (!stall) begin
            // Decode took the presented word (or nothing was presented): move on
            m_cur   = m_next;
            m_next  = m_next + 32'd4;
            m_valid = 1'b1;
            if (word_oor(m_cur)) m_err = 1'b1;
        end
    end

    // Compare process: every negedge against the model, plus a stream-order check
    bit          have_last = 1'b0;
    logic [31:0] last_pc   = '0;

    always @(negedge clk) begin
        logic        exp_valid;
        logic [31:0] exp_addr;
        exp_valid = m_valid && !redirect_valid;
        if (redirect_valid)          exp_addr = redirect_pc & ~32'd3;
        else if (stall && m_valid)   exp_addr = m_cur;
        else                         exp_addr = m_next;
        chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
        chk("imem_addr", imem_addr, exp_addr);
        chk("inst_pc", inst_pc, m_cur);
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
        if (exp_valid) chk("inst", inst, word_oor(m_cur) ? NOP_INST : rom_word(m_cur));
        if (rst || redirect_valid) begin
            have_last = 1'b0;
        end else if (inst_valid && !stall) begin
            if (have_last) chk("stream_order", inst_pc, last_pc + 32'd4);
            last_pc   = inst_pc;
            have_last = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic st);
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall          = st;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        tick();
        rst = 1'b0;

        // Reset release: one empty cycle, then 0,4,8
        @(negedge clk);
        chk("first_bubble", 32'(inst_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("w0_pc", inst_pc, 32'h0);
        chk("w0", inst, rom_word(32'h0));
        tick();
        @(negedge clk);
        chk("w1_pc", inst_pc, 32'h4);
        tick();

        // Three stall cycles while (8,W2) is presented
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_addr", imem_addr, 32'h8);
            chk("stall_pc", inst_pc, 32'h8);
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_inst", inst, rom_word(32'h8));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("stall_drop_pc", inst_pc, 32'h8);
        tick();
        @(negedge clk);
        chk("after_stall_pc", inst_pc, 32'hC);
        chk("after_stall_inst", inst, rom_word(32'hC));
        tick();

        // Redirect to 0x100 squashes the presented word
        drive(1'b1, 32'h100, 1'b0);
        @(negedge clk);
        chk("redir_squash", 32'(inst_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("redir_pc", inst_pc, 32'h100);
        chk("redir_inst", inst, rom_word(32'h100));
        tick();
        @(negedge clk);
        chk("redir_next_pc", inst_pc, 32'h104);
        tick();

        // Redirect together with stall: redirect wins, then the stall holds 0x40
        drive(1'b1, 32'h40, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("rs_pc", inst_pc, 32'h40);
        chk("rs_valid", 32'(inst_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("rs_hold_pc", inst_pc, 32'h40);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        tick();

        // Misaligned redirect: fetch from 0x100, sticky error
        drive(1'b1, 32'h102, 1'b0);
        @(negedge clk);
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_err_before", 32'(fetch_err), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("mis_pc", inst_pc, 32'h100);
        chk("mis_err", 32'(fetch_err), 32'd1);
        tick();
        tick();
        @(negedge clk);
        chk("mis_err_sticky", 32'(fetch_err), 32'd1);

        // Asynchronous reset mid-cycle clears everything at once
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_err", 32'(fetch_err), 32'd0);
        chk("async_valid", 32'(inst_valid), 32'd0);
        chk("async_pc", inst_pc, 32'd0);
        chk("async_addr", imem_addr, RESET_PC);
        tick();
        rst = 1'b0;

        // Top of ROM: 0x3FFC is fine, 0x4000 is a NOP with error
        drive(1'b1, 32'h3FFC, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("top_pc", inst_pc, 32'h3FFC);
        chk("top_inst", inst, rom_word(32'h3FFC));
        chk("top_err", 32'(fetch_err), 32'd0);
        tick();
        @(negedge clk);
        chk("oor_pc", inst_pc, 32'h4000);
        chk("oor_inst", inst, 32'h0000_0013);
        chk("oor_err", 32'(fetch_err), 32'd1);
        tick();

        // Randomized stall / redirect / reset traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            case ($urandom_range(0, 3))
                0:       tgt = 32'($urandom_range(0, 4095)) << 2;
                1:       tgt = 32'h3FF0 + 32'($urandom_range(0, 15));
                2:       tgt = $urandom();
                default: tgt = (32'($urandom_range(0, 4095)) << 2) | 32'($urandom_range(0, 3));
            endcase
            drive($urandom_range(0, 7) == 0, tgt, $urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
